// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a 32-bit register to byte/half/word and streams it as byte-lane memory writes
module store_narrow_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              trunc_loss,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready
);
    typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

    state_t            state, state_n;
    logic [1:0]        idx, idx_n, last, last_n;
    logic [31:0]       data, data_n;
    logic              busy_n, done_n, error_n, trunc_n, we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wd_n;
    logic              legal, loss;

    assign legal = (size == 2'b00) || (size == 2'b01 && !addr[0]) || (size == 2'b10 && addr[1:0] == 2'b00);
    assign loss  = (size == 2'b00) ? (wdata[31:8] != {24{wdata[7]}}) :
                   (size == 2'b01) ? (wdata[31:16] != {16{wdata[15]}}) : 1'b0;

    // Next-state and next-output logic; data is kept pre-shifted so the next lane is always data[15:8]
    always_comb begin
        state_n = state;
        idx_n   = idx;
        last_n  = last;
        data_n  = data;
        done_n  = 1'b0;
        error_n = error;
        trunc_n = trunc_loss;
        we_n    = mem_we;
        addr_n  = mem_addr;
        wd_n    = mem_wdata;
        case (state)
            IDLE: begin
                if (start && legal) begin
                    state_n = WRITE;
                    idx_n   = 2'd0;
                    last_n  = (size == 2'b00) ? 2'd0 : (size == 2'b01) ? 2'd1 : 2'd3;
                    data_n  = wdata;
                    error_n = 1'b0;
                    trunc_n = loss;
                    we_n    = 1'b1;
                    addr_n  = addr;
                    wd_n    = wdata[7:0];
                end else if (start) begin
                    state_n = FINISH;
                    error_n = 1'b1;
                    trunc_n = 1'b0;
                    done_n  = 1'b1;
                end
            end
            WRITE: begin
                if (mem_ready && idx == last) begin
                    state_n = FINISH;
                    we_n    = 1'b0;
                    done_n  = 1'b1;
                end else if (mem_ready) begin
                    idx_n  = idx + 2'd1;
                    data_n = data >> 8;
                    wd_n   = data[15:8];
                    addr_n = mem_addr + ADDR_W'(1);
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and registered outputs; async reset abandons any in-flight store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            last       <= 2'd0;
            data       <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            trunc_loss <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            last       <= last_n;
            data       <= data_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
            trunc_loss <= trunc_n;
            mem_we     <= we_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wd_n;
        end
    end
endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit: directed self-checking bench for store_narrow_unit
module tb_store_narrow_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, mem_ready;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, error, trunc_loss, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    int checks = 0;
    int failures = 0;

    store_narrow_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .error(error), .trunc_loss(trunc_loss),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Watchdog so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        size = s; addr = a; wdata = d; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [31:0] a, input logic [7:0] d);
        chk({tag, "_we"}, 64'(mem_we), 64'd1);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(a));
        chk({tag, "_data"}, 64'(mem_wdata), 64'(d));
    endtask

    task automatic chk_done(input string tag, input logic e, input logic t);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_we0"}, 64'(mem_we), 64'd0);
        chk({tag, "_err"}, 64'(error), 64'(e));
        chk({tag, "_trunc"}, 64'(trunc_loss), 64'(t));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_done0"}, 64'(done), 64'd0);
        chk({tag, "_busy0"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int writes;
        bit seen;
        rst_n = 1'b0; start = 1'b0; size = 2'b00; addr = 0; wdata = 0; mem_ready = 1'b1;
        tick(); tick();
        chk("rst_outs", 64'({busy, done, error, trunc_loss, mem_we}), 64'd0);
        chk("rst_addr", 64'({mem_addr, mem_wdata}), 64'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_outs", 64'({busy, done, error, trunc_loss, mem_we}), 64'd0);

        // Byte store with truncation loss
        req(2'b00, 32'h10, 32'h0000_00AB);
        chk_write("byte_c1", 32'h10, 8'hAB);
        chk("byte_c1_busy", 64'(busy), 64'd1);
        chk("byte_c1_done0", 64'(done), 64'd0);
        tick();
        chk_done("byte_c2", 1'b0, 1'b1);
        tick();
        chk_idle("byte_c3");
        chk("byte_hold_trunc", 64'(trunc_loss), 64'd1);

        // Half store, no loss
        req(2'b01, 32'h22, 32'hFFFF_8001);
        chk_write("half_c1", 32'h22, 8'h01);
        tick();
        chk_write("half_c2", 32'h23, 8'h80);
        tick();
        chk_done("half_c3", 1'b0, 1'b0);
        tick();
        chk_idle("half_c4");

        // Half store with loss
        req(2'b01, 32'h30, 32'h0001_7FFF);
        tick(); tick();
        chk_done("half_loss", 1'b0, 1'b1);
        tick();

        // Word store with two stall cycles on the second byte
        req(2'b10, 32'h40, 32'h1122_3344);
        chk_write("word_c1", 32'h40, 8'h44);
        tick();
        mem_ready = 1'b0;
        chk_write("word_c2", 32'h41, 8'h33);
        tick();
        chk_write("word_c3_stall", 32'h41, 8'h33);
        tick();
        chk_write("word_c4_stall", 32'h41, 8'h33);
        mem_ready = 1'b1;
        tick();
        chk_write("word_c5", 32'h42, 8'h22);
        tick();
        chk_write("word_c6", 32'h43, 8'h11);
        tick();
        chk_done("word_c7", 1'b0, 1'b0);
        tick();
        chk_idle("word_c8");

        // Byte at top of address space, negative value sign-extended: no loss
        req(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FF80);
        chk_write("top_c1", 32'hFFFF_FFFF, 8'h80);
        tick();
        chk_done("top_c2", 1'b0, 1'b0);
        tick();

        // Illegal requests: done with error in cycle 1, never a write
        req(2'b01, 32'h21, 32'h1234_5678);
        chk_done("mis_half", 1'b1, 1'b0);
        chk("mis_half_busy", 64'(busy), 64'd1);
        tick();
        chk_idle("mis_half_idle");
        chk("err_hold", 64'(error), 64'd1);
        req(2'b11, 32'h0, 32'hFFFF_0000);
        chk_done("bad_size", 1'b1, 1'b0);
        tick();
        chk_idle("bad_size_idle");
        req(2'b10, 32'h42, 32'h0000_0001);
        chk_done("mis_word", 1'b1, 1'b0);
        tick();
        chk_idle("mis_word_idle");

        // Start while busy is ignored: exactly four writes
        req(2'b10, 32'h100, 32'hA1B2_C3D4);
        writes = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (i == 1) begin
                size = 2'b00; addr = 32'h200; start = 1'b1;
            end else start = 1'b0;
            if (mem_we) writes++;
            if (done) seen = 1'b1;
            else tick();
        end
        start = 1'b0;
        chk("busy_start_done_seen", 64'(seen), 64'd1);
        chk("busy_start_writes", 64'(writes), 64'd4);
        tick();
        chk_idle("busy_start_idle");
        tick();
        chk("busy_start_not_queued", 64'({busy, mem_we}), 64'd0);

        // Async reset during the third byte of a word store
        req(2'b10, 32'h60, 32'hDEAD_BEEF);
        tick(); tick();
        chk_write("rst_mid_c3", 32'h62, 8'hAD);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 64'(mem_we), 64'd0);
        chk("rst_mid_outs", 64'({busy, done, error, trunc_loss}), 64'd0);
        chk("rst_mid_addr", 64'({mem_addr, mem_wdata}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("rst_mid_no_resume", 64'({busy, done, mem_we}), 64'd0);
        req(2'b00, 32'h80, 32'h0000_007F);
        chk_write("after_rst_c1", 32'h80, 8'h7F);
        tick();
        chk_done("after_rst_c2", 1'b0, 1'b0);
        tick();
        chk_idle("after_rst_c3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
